lsu_stage: RTL

LSU_STAGE -- requirements
Module: lsu_stage

---
 rtl/lsu_stage_pkg.sv | 37 +++
 rtl/lsu_stage_lane_sel.sv | 43 ++++
 rtl/lsu_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lsu_stage_pkg.sv
// Purpose : shared types for the load/store stage (memory op encoding, FSM states, request record).
// Latency : n/a (types and helper functions only).
// Backpr.  : n/a.
package lsu_stage_pkg;

  // Memory op encoding as produced by the ALU stage.
  typedef enum logic [1:0] {
    OP_LW  = 2'b00,
    OP_LBU = 2'b01,
    OP_SW  = 2'b10,
    OP_SB  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_REQ       = 2'b01,
    ST_WAIT_RESP = 2'b10
  } state_e;

  // Request captured on acceptance and held for the whole transaction.
  typedef struct packed {
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd_idx;
  } req_t;

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  // Word ops need a word-aligned address; byte ops may use any lane.
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] byte_off);
    return ((op == OP_LW) || (op == OP_SW)) && (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_stage_lane_sel.sv
// Purpose : byte-lane write mask / store-data replication and LBU byte extraction.
// Latency : combinational.
// Backpr.  : none (pure function of its inputs).
// Ports   : op, byte_off -> we, mask, wdata_rep (store side); rdata -> load_data (load side).
module lsu_lane_sel
  import lsu_stage_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        we,
  output logic [3:0]  mask,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  always_comb begin
    we        = 1'b0;
    mask      = 4'b0000;
    wdata_rep = wdata;
    load_data = rdata;
    case (op)
      OP_SW: begin
        we   = 1'b1;
        mask = 4'b1111;
      end
      OP_SB: begin
        we        = 1'b1;
        mask      = 4'b0001 << byte_off;
        // Replicate so the selected lane carries the byte whatever the offset.
        wdata_rep = {4{wdata[7:0]}};
      end
      OP_LBU: begin
        // Little-endian: offset 0 is bits [7:0].
        load_data = {24'd0, rdata[{byte_off, 3'b000} +: 8]};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Purpose : single-outstanding load/store stage between ALU and a valid/yumi memory port.
// Latency : load writeback 1 cycle after the response (>= 3 cycles after acceptance); stores retire on yumi.
// Backpr.  : ready_o only in IDLE; request held stable on mem_v_o until mem_yumi_i; loads abort after TIMEOUT_CYCLES.
// Ports   : ALU side valid_i/ready_o/op_i/addr_i/wdata_i/rd_idx_i; writeback wb_*; error pulse err_o;
//           memory side mem_v_o/mem_addr_o/mem_we_o/mem_mask_o/mem_wdata_o/mem_yumi_i/mem_resp_*.
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        n_reset_i,
  input  logic        valid_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_idx_i,
  output logic        ready_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_idx_o,
  output logic        err_o,
  output logic        mem_v_o,
  output logic [29:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_mask_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_yumi_i,
  input  logic        mem_resp_v_i,
  input  logic [31:0] mem_resp_data_i
);

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  req_t        req_q, req_in;
  logic [7:0]  cnt_q, cnt_d;
  logic [8:0]  cnt_inc;
  logic        err_q, err_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_idx_q;
  logic        latch_en, wb_load_en;

  logic        lane_we;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load_data;

  assign req_in = '{op: mem_op_e'(op_i), addr: addr_i, wdata: wdata_i, rd_idx: rd_idx_i};
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  lsu_lane_sel u_lane_sel (
    .op        (req_q.op),
    .byte_off  (req_q.addr[1:0]),
    .wdata     (req_q.wdata),
    .rdata     (mem_resp_data_i),
    .we        (lane_we),
    .mask      (lane_mask),
    .wdata_rep (lane_wdata),
    .load_data (lane_load_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    wb_valid_d = 1'b0;
    latch_en   = 1'b0;
    wb_load_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          latch_en = 1'b1;
          // Misaligned word ops are rejected here and never reach memory.
          if (is_misaligned(mem_op_e'(op_i), addr_i[1:0])) err_d = 1'b1;
          else                                              state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_yumi_i) begin
          if (is_store(req_q.op)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RESP;
            cnt_d   = 8'd0;
          end
        end
      end
      ST_WAIT_RESP: begin
        // A response arriving on the final counted cycle still wins over the timeout.
        if (mem_resp_v_i) begin
          wb_load_en = 1'b1;
          wb_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_inc == TO_LIM) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
      wb_idx_q   <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      wb_valid_q <= wb_valid_d;
      if (latch_en) req_q <= req_in;
      // Writeback data holds between pulses.
      if (wb_load_en) begin
        wb_data_q <= lane_load_data;
        wb_idx_q  <= req_q.rd_idx;
      end
    end
  end

  assign ready_o     = (state_q == ST_IDLE);
  assign mem_v_o     = (state_q == ST_REQ);
  assign mem_addr_o  = mem_v_o ? req_q.addr[31:2] : 30'd0;
  assign mem_we_o    = mem_v_o & lane_we;
  assign mem_mask_o  = mem_v_o ? lane_mask : 4'b0000;
  assign mem_wdata_o = mem_v_o ? lane_wdata : 32'd0;
  assign wb_valid_o  = wb_valid_q;
  assign wb_data_o   = wb_data_q;
  assign wb_idx_o    = wb_idx_q;
  assign err_o       = err_q;

endmodule
